fetch_stage_ctrl: RTL

FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

---
 rtl/fetch_stage_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage_ctrl.sv
// Instruction fetch stage controller: issues one outstanding imem request at a time,
// buffers responses under IF/ID stalls, squashes on flush and keeps stall/flush counters.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_disable_i,
  input  logic               ifid_disable_i,
  input  logic               flush_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        pc_ifid_o,
  output logic [31:0]        instr_ifid_o,
  output logic               valid_ifid_o,
  output logic [COUNT_W-1:0] stall_cnt_o,
  output logic [COUNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  state_t             state;
  state_t             next_state;
  logic               accept;
  logic               resp_live;
  logic [31:0]        pc;
  logic [31:0]        req_pc;
  logic [31:0]        buf_instr;
  logic [31:0]        buf_pc;
  logic [31:0]        ifid_pc;
  logic [31:0]        ifid_instr;
  logic               ifid_valid;
  logic [COUNT_W-1:0] stall_cnt;
  logic [COUNT_W-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH: begin
        if (accept) begin
          next_state = flush_i ? ST_DISCARD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (flush_i || !ifid_disable_i) begin
            next_state = ST_FETCH;
          end else begin
            next_state = ST_HOLD;
          end
        end else if (flush_i) begin
          next_state = ST_DISCARD;
        end
      end
      ST_HOLD: begin
        if (flush_i || !ifid_disable_i) begin
          next_state = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (imem_rvalid_i) begin
          next_state = ST_FETCH;
        end
      end
      default: next_state = ST_FETCH;
    endcase
  end

  // A response is only meaningful in WAIT; rvalid seen in any other state is stale.
  always_comb begin
    imem_req_o = (state == ST_FETCH) && !pc_disable_i;
    resp_live  = (state == ST_WAIT) && imem_rvalid_i && !flush_i;
  end

  assign accept = imem_req_o && imem_gnt_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      req_pc     <= '0;
      buf_instr  <= '0;
      buf_pc     <= '0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else begin
      if (flush_i) begin
        pc <= redirect_pc_i;
      end else if (accept) begin
        pc <= pc + 32'd4;
      end

      if (accept && !flush_i) begin
        req_pc <= pc;
      end

      if (resp_live && ifid_disable_i) begin
        buf_instr <= imem_rdata_i;
        buf_pc    <= req_pc;
      end

      // Flush beats a stall; an enabled register with nothing to take gets a bubble.
      if (flush_i) begin
        ifid_pc    <= '0;
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end else if (!ifid_disable_i) begin
        if (resp_live) begin
          ifid_pc    <= req_pc;
          ifid_instr <= imem_rdata_i;
          ifid_valid <= 1'b1;
        end else if (state == ST_HOLD) begin
          ifid_pc    <= buf_pc;
          ifid_instr <= buf_instr;
          ifid_valid <= 1'b1;
        end else begin
          ifid_instr <= '0;
          ifid_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ifid_disable_i && !flush_i && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_i && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

  assign imem_addr_o  = pc;
  assign pc_ifid_o    = ifid_pc;
  assign instr_ifid_o = ifid_instr;
  assign valid_ifid_o = ifid_valid;
  assign stall_cnt_o  = stall_cnt;
  assign flush_cnt_o  = flush_cnt;

endmodule
